// File: rtl/issue_station_if.sv
// Dispatch, result-bus and issue signals of the ALU/branch reservation station.
// master = dispatch/execute side, slave = station.
interface issue_station_if #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int ROB_W  = 4,
  parameter int OP_W   = 6,
  parameter int NCDB   = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                   in_valid;
  logic                   in_ready;
  logic [OP_W-1:0]        in_op;
  logic [DATA_W-1:0]      in_v1;
  logic [DATA_W-1:0]      in_v2;
  logic [ROB_W-1:0]       in_q1;
  logic [ROB_W-1:0]       in_q2;
  logic [ADDR_W-1:0]      in_pc;
  logic [DATA_W-1:0]      in_imm;
  logic [ROB_W-1:0]       in_rob;

  logic [NCDB-1:0]        cdb_valid;
  logic [NCDB*ROB_W-1:0]  cdb_rob;
  logic [NCDB*DATA_W-1:0] cdb_data;

  logic                   out_valid;
  logic                   out_ready;
  logic [OP_W-1:0]        out_op;
  logic [DATA_W-1:0]      out_v1;
  logic [DATA_W-1:0]      out_v2;
  logic [ADDR_W-1:0]      out_pc;
  logic [DATA_W-1:0]      out_imm;
  logic [ROB_W-1:0]       out_rob;

  logic [CW-1:0]          count;

  modport master (
    output in_valid, in_op, in_v1, in_v2, in_q1, in_q2,
    output in_pc, in_imm, in_rob,
    output cdb_valid, cdb_rob, cdb_data, out_ready,
    input  in_ready, out_valid, out_op, out_v1, out_v2,
    input  out_pc, out_imm, out_rob, count
  );

  modport slave (
    input  in_valid, in_op, in_v1, in_v2, in_q1, in_q2,
    input  in_pc, in_imm, in_rob,
    input  cdb_valid, cdb_rob, cdb_data, out_ready,
    output in_ready, out_valid, out_op, out_v1, out_v2,
    output out_pc, out_imm, out_rob, count
  );
endinterface

// File: rtl/issue_station.sv
// Reservation station: in-place operand wakeup from result buses,
// oldest-ready selection via age matrix, registered issue stage.
module issue_station #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int ROB_W  = 4,
  parameter int OP_W   = 6,
  parameter int NCDB   = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rdy,
  input  logic           flush,
  issue_station_if.slave io
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  localparam int EW = ROB_W + DATA_W;

  logic [DEPTH-1:0]       busy;
  logic [DEPTH-1:0]       older [DEPTH];
  logic [OP_W-1:0]        e_op  [DEPTH];
  logic [DATA_W-1:0]      e_v1  [DEPTH];
  logic [DATA_W-1:0]      e_v2  [DEPTH];
  logic [ROB_W-1:0]       e_q1  [DEPTH];
  logic [ROB_W-1:0]       e_q2  [DEPTH];
  logic [ADDR_W-1:0]      e_pc  [DEPTH];
  logic [DATA_W-1:0]      e_imm [DEPTH];
  logic [ROB_W-1:0]       e_rob [DEPTH];

  logic                   iss_valid;
  logic [OP_W-1:0]        iss_op;
  logic [DATA_W-1:0]      iss_v1;
  logic [DATA_W-1:0]      iss_v2;
  logic [ADDR_W-1:0]      iss_pc;
  logic [DATA_W-1:0]      iss_imm;
  logic [ROB_W-1:0]       iss_rob;

  logic [NCDB-1:0]        cv;
  logic [NCDB*ROB_W-1:0]  ctag;
  logic [NCDB*DATA_W-1:0] cdat;

  logic [DEPTH-1:0]       ready;
  logic [DEPTH-1:0]       blk;
  logic [IW-1:0]          sel;
  logic [IW-1:0]          slot;
  logic [CW-1:0]          cnt;
  logic                   alloc;
  logic                   issue;
  logic [EW-1:0]          w1 [DEPTH];
  logic [EW-1:0]          w2 [DEPTH];
  logic [EW-1:0]          n1;
  logic [EW-1:0]          n2;

  assign cv   = io.cdb_valid;
  assign ctag = io.cdb_rob;
  assign cdat = io.cdb_data;

  // Returns {q, v}; scanning high-to-low lets the lowest bus win.
  function automatic logic [EW-1:0] wake(
    input logic [ROB_W-1:0]  q,
    input logic [DATA_W-1:0] v
  );
    logic [EW-1:0] r;
    r = {q, v};
    for (int k = NCDB - 1; k >= 0; k--)
      if (cv[k] && q != '0 && ctag[k*ROB_W +: ROB_W] == q)
        r = {{ROB_W{1'b0}}, cdat[k*DATA_W +: DATA_W]};
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w1[i]    = wake(e_q1[i], e_v1[i]);
      w2[i]    = wake(e_q2[i], e_v2[i]);
      ready[i] = busy[i] && e_q1[i] == '0 && e_q2[i] == '0;
    end
  end

  assign n1 = wake(io.in_q1, io.in_v1);
  assign n2 = wake(io.in_q2, io.in_v2);

  always_comb begin
    blk = '0;
    sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++)
        blk[i] = blk[i] | (ready[j] & older[j][i]);
      if (ready[i] && !blk[i])
        sel = IW'(i);
    end
  end

  always_comb begin
    slot = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!busy[i])
        slot = IW'(i);
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < DEPTH; i++)
      cnt = cnt + CW'(busy[i]);
  end

  assign io.in_ready = rdy & ~(&busy);
  assign alloc       = io.in_valid & io.in_ready;
  assign issue       = rdy & (|ready) & (~iss_valid | io.out_ready);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      busy      <= '0;
      iss_valid <= 1'b0;
      iss_op    <= '0;
      iss_v1    <= '0;
      iss_v2    <= '0;
      iss_pc    <= '0;
      iss_imm   <= '0;
      iss_rob   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        older[i] <= '0;
        e_q1[i]  <= '0;
        e_q2[i]  <= '0;
      end
    end else if (rdy) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (busy[i]) begin
          {e_q1[i], e_v1[i]} <= w1[i];
          {e_q2[i], e_v2[i]} <= w2[i];
        end
      end
      if (alloc) begin
        busy[slot]             <= 1'b1;
        e_op[slot]             <= io.in_op;
        {e_q1[slot], e_v1[slot]} <= n1;
        {e_q2[slot], e_v2[slot]} <= n2;
        e_pc[slot]             <= io.in_pc;
        e_imm[slot]            <= io.in_imm;
        e_rob[slot]            <= io.in_rob;
        older[slot]            <= '0;
        for (int j = 0; j < DEPTH; j++)
          older[j][slot] <= busy[j];
      end
      if (issue) begin
        busy[sel] <= 1'b0;
        iss_valid <= 1'b1;
        iss_op    <= e_op[sel];
        iss_v1    <= e_v1[sel];
        iss_v2    <= e_v2[sel];
        iss_pc    <= e_pc[sel];
        iss_imm   <= e_imm[sel];
        iss_rob   <= e_rob[sel];
      end else if (iss_valid && io.out_ready) begin
        iss_valid <= 1'b0;
      end
    end
  end

  assign io.out_valid = iss_valid;
  assign io.out_op    = iss_op;
  assign io.out_v1    = iss_v1;
  assign io.out_v2    = iss_v2;
  assign io.out_pc    = iss_pc;
  assign io.out_imm   = iss_imm;
  assign io.out_rob   = iss_rob;
  assign io.count     = cnt;
endmodule

// File: tb/tb_issue_station.sv
// Bench for issue_station: directed scenarios plus random traffic,
// all checked against an oldest-first queue model of the station.
module tb_issue_station;
  localparam int DEPTH  = 8;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int ROB_W  = 4;
  localparam int OP_W   = 6;
  localparam int NCDB   = 2;
  localparam int CW     = $clog2(DEPTH) + 1;
  localparam int OW     = OP_W + 3 * DATA_W + ADDR_W + ROB_W;
  localparam int VW     = OW + CW + 2;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] v1;
    logic [DATA_W-1:0] v2;
    logic [ROB_W-1:0]  q1;
    logic [ROB_W-1:0]  q2;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] imm;
    logic [ROB_W-1:0]  rob;
  } ent_t;

  logic clk = 1'b0;
  logic rst, rdy, flush;
  logic in_valid, out_ready;
  ent_t din;
  logic [NCDB-1:0]        bv;
  logic [NCDB*ROB_W-1:0]  brob;
  logic [NCDB*DATA_W-1:0] bdat;

  int checks = 0;
  int passed = 0;

  ent_t mq[$];
  logic m_ov;
  ent_t m_out;

  always #5 clk = ~clk;

  issue_station_if #(
    .DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .ROB_W(ROB_W), .OP_W(OP_W), .NCDB(NCDB)
  ) io ();

  assign io.in_valid  = in_valid;
  assign io.in_op     = din.op;
  assign io.in_v1     = din.v1;
  assign io.in_v2     = din.v2;
  assign io.in_q1     = din.q1;
  assign io.in_q2     = din.q2;
  assign io.in_pc     = din.pc;
  assign io.in_imm    = din.imm;
  assign io.in_rob    = din.rob;
  assign io.cdb_valid = bv;
  assign io.cdb_rob   = brob;
  assign io.cdb_data  = bdat;
  assign io.out_ready = out_ready;

  issue_station #(
    .DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .ROB_W(ROB_W), .OP_W(OP_W), .NCDB(NCDB)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .io(io)
  );

  function automatic ent_t wake_ent(ent_t e);
    ent_t r = e;
    if (r.q1 != 0)
      for (int k = 0; k < NCDB; k++)
        if (bv[k] && brob[k*ROB_W +: ROB_W] == r.q1) begin
          r.v1 = bdat[k*DATA_W +: DATA_W];
          r.q1 = '0;
          break;
        end
    if (r.q2 != 0)
      for (int k = 0; k < NCDB; k++)
        if (bv[k] && brob[k*ROB_W +: ROB_W] == r.q2) begin
          r.v2 = bdat[k*DATA_W +: DATA_W];
          r.q2 = '0;
          break;
        end
    return r;
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    logic [OW-1:0] f;
    f = io.out_valid ? {io.out_op, io.out_v1, io.out_v2,
                        io.out_pc, io.out_imm, io.out_rob} : '0;
    return {io.out_valid, f, io.count, io.in_ready};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic [OW-1:0] f;
    f = m_ov ? {m_out.op, m_out.v1, m_out.v2,
                m_out.pc, m_out.imm, m_out.rob} : '0;
    return {m_ov, f, CW'(mq.size()), rdy && (mq.size() < DEPTH)};
  endfunction

  // Advance one clock; the model moves with the same inputs.
  task automatic tick();
    ent_t nq[$];
    logic nov;
    ent_t no;
    int   ri;
    logic acc;
    acc = in_valid && rdy && (mq.size() < DEPTH);
    nq  = mq;
    nov = m_ov;
    no  = m_out;
    if (flush) begin
      nq.delete();
      nov = 1'b0;
      no  = '0;
    end else if (rdy) begin
      ri = -1;
      foreach (mq[i])
        if (ri < 0 && mq[i].q1 == 0 && mq[i].q2 == 0) ri = i;
      if (ri >= 0 && (!m_ov || out_ready)) begin
        no  = mq[ri];
        nov = 1'b1;
        nq.delete(ri);
      end else if (m_ov && out_ready) begin
        nov = 1'b0;
      end
      foreach (nq[i]) nq[i] = wake_ent(nq[i]);
      if (acc) nq.push_back(wake_ent(din));
    end
    @(posedge clk);
    #1;
    mq    = nq;
    m_ov  = nov;
    m_out = no;
  endtask

  task automatic set_in(input int rob, input int q1, input int q2,
                        input logic [DATA_W-1:0] v1,
                        input logic [DATA_W-1:0] v2);
    din.op  = OP_W'($urandom_range(1, 63));
    din.rob = ROB_W'(rob);
    din.q1  = ROB_W'(q1);
    din.q2  = ROB_W'(q2);
    din.v1  = v1;
    din.v2  = v2;
    din.pc  = $urandom;
    din.imm = $urandom;
  endtask

  task automatic set_bus(input int k, input int tag,
                         input logic [DATA_W-1:0] d);
    bv[k]                   = 1'b1;
    brob[k*ROB_W +: ROB_W]  = ROB_W'(tag);
    bdat[k*DATA_W +: DATA_W] = d;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    bv       = '0;
    flush    = 1'b0;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete();
    m_ov  = 1'b0;
    m_out = '0;
    if (io.count !== CW'(0))
      $display("FAIL reset_count: got %0d want 0", io.count);
    else passed++;
    checks++;
    if (io.out_valid !== 1'b0)
      $display("FAIL reset_out_valid: got %b want 0", io.out_valid);
    else passed++;
    checks++;
    if (io.in_ready !== 1'b1)
      $display("FAIL reset_in_ready: got %b want 1", io.in_ready);
    else passed++;
    checks++;
    if ({io.out_rob, io.out_v1} !== {4'd0, 32'd0})
      $display("FAIL reset_out_regs: got %h %h want 0", io.out_rob, io.out_v1);
    else passed++;
    checks++;
  endtask

  task automatic test_min_latency();
    out_ready = 1'b1;
    set_in(3, 0, 0, 32'd5, 32'd7);
    din.op   = 6'd1;
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      in_valid = 1'b0;
      if (obs_vec() !== exp_vec())
        $display("FAIL latency_model: dut=%h model=%h", obs_vec(), exp_vec());
      else passed++;
      checks++;
      if (c == 1) begin
        if ({io.out_valid, io.out_rob, io.out_v1, io.out_v2} !==
            {1'b1, 4'd3, 32'd5, 32'd7})
          $display("FAIL latency_issue: got v=%b rob=%0d v1=%0d v2=%0d want 1 3 5 7",
                   io.out_valid, io.out_rob, io.out_v1, io.out_v2);
        else passed++;
        checks++;
      end
    end
    if ({io.out_valid, io.count} !== {1'b0, 4'd0})
      $display("FAIL latency_drain: got v=%b cnt=%0d want 0 0", io.out_valid, io.count);
    else passed++;
    checks++;
  endtask

  task automatic test_wakeup();
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b0;
      bv       = '0;
      if (c == 0) begin set_in(1, 9, 0, 32'd0, 32'd11); in_valid = 1'b1; end
      if (c == 1) begin set_in(2, 0, 0, 32'd20, 32'd21); in_valid = 1'b1; end
      if (c == 3) set_bus(1, 9, 32'h55);
      tick();
      if (obs_vec() !== exp_vec())
        $display("FAIL wakeup_model: dut=%h model=%h", obs_vec(), exp_vec());
      else passed++;
      checks++;
      if (c == 2) begin
        if ({io.out_valid, io.out_rob} !== {1'b1, 4'd2})
          $display("FAIL wakeup_first: got v=%b rob=%0d want 1 2", io.out_valid, io.out_rob);
        else passed++;
        checks++;
      end
      if (c == 4) begin
        if ({io.out_valid, io.out_rob, io.out_v1} !== {1'b1, 4'd1, 32'h55})
          $display("FAIL wakeup_second: got v=%b rob=%0d v1=%h want 1 1 55",
                   io.out_valid, io.out_rob, io.out_v1);
        else passed++;
        checks++;
      end
    end
    idle(2);
  endtask

  task automatic test_bypass();
    out_ready = 1'b1;
    set_in(5, 0, 4, 32'd1, 32'd0);
    in_valid = 1'b1;
    bv       = '0;
    set_bus(0, 4, 32'hAB);
    tick();
    if (obs_vec() !== exp_vec())
      $display("FAIL bypass_model: dut=%h model=%h", obs_vec(), exp_vec());
    else passed++;
    checks++;
    in_valid = 1'b0;
    bv       = '0;
    tick();
    if ({io.out_valid, io.out_rob, io.out_v1, io.out_v2} !==
        {1'b1, 4'd5, 32'd1, 32'hAB})
      $display("FAIL bypass_issue: got v=%b rob=%0d v1=%h v2=%h want 1 5 1 ab",
               io.out_valid, io.out_rob, io.out_v1, io.out_v2);
    else passed++;
    checks++;
    idle(2);
  endtask

  task automatic test_full_order();
    int exp_order[$];
    int got[$];
    int rob;
    out_ready = 1'b1;
    bv        = '0;
    set_in(1, 0, 0, 32'd1, 32'd1); in_valid = 1'b1; tick();
    set_in(2, 6, 0, 32'd0, 32'd2); tick();
    exp_order.push_back(2);
    set_in(3, 0, 0, 32'd3, 32'd3); tick();
    idle(3);
    rob = 4;
    for (int n = 0; n < 2 * DEPTH && io.in_ready; n++) begin
      set_in(rob, 6, 0, 32'd0, 32'(rob));
      in_valid = 1'b1;
      exp_order.push_back(rob);
      rob++;
      tick();
      if (obs_vec() !== exp_vec())
        $display("FAIL full_fill_model: dut=%h model=%h", obs_vec(), exp_vec());
      else passed++;
      checks++;
    end
    in_valid = 1'b0;
    if ({io.in_ready, io.count} !== {1'b0, CW'(DEPTH)})
      $display("FAIL full_state: got rdy=%b cnt=%0d want 0 %0d",
               io.in_ready, io.count, DEPTH);
    else passed++;
    checks++;
    set_bus(0, 6, 32'h66);
    tick();
    bv = '0;
    for (int c = 0; c < DEPTH + 2; c++) begin
      tick();
      if (obs_vec() !== exp_vec())
        $display("FAIL full_drain_model: dut=%h model=%h", obs_vec(), exp_vec());
      else passed++;
      checks++;
      if (io.out_valid) got.push_back(int'(io.out_rob));
    end
    if (got.size() != exp_order.size())
      $display("FAIL full_issue_count: got %0d want %0d", got.size(), exp_order.size());
    else passed++;
    checks++;
    for (int i = 0; i < exp_order.size() && i < got.size(); i++) begin
      if (got[i] != exp_order[i])
        $display("FAIL full_order[%0d]: got rob %0d want rob %0d", i, got[i], exp_order[i]);
      else passed++;
      checks++;
    end
  endtask

  task automatic test_backpressure();
    logic [OW-1:0] snap;
    out_ready = 1'b0;
    bv        = '0;
    for (int r = 7; r <= 9; r++) begin
      set_in(r, 0, 0, 32'(r * 3), 32'(r * 5));
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    snap = {io.out_op, io.out_v1, io.out_v2, io.out_pc, io.out_imm, io.out_rob};
    for (int c = 0; c < 4; c++) begin
      tick();
      if ({io.out_valid, io.out_rob, io.count} !== {1'b1, 4'd7, CW'(2)})
        $display("FAIL stall_state: got v=%b rob=%0d cnt=%0d want 1 7 2",
                 io.out_valid, io.out_rob, io.count);
      else passed++;
      checks++;
      if ({io.out_op, io.out_v1, io.out_v2, io.out_pc, io.out_imm, io.out_rob} !== snap)
        $display("FAIL stall_hold: out fields changed while stalled");
      else passed++;
      checks++;
    end
    out_ready = 1'b1;
    for (int r = 8; r <= 9; r++) begin
      tick();
      if ({io.out_valid, io.out_rob} !== {1'b1, 4'(r)})
        $display("FAIL release_issue: got v=%b rob=%0d want 1 %0d",
                 io.out_valid, io.out_rob, r);
      else passed++;
      checks++;
      if (obs_vec() !== exp_vec())
        $display("FAIL release_model: dut=%h model=%h", obs_vec(), exp_vec());
      else passed++;
      checks++;
    end
    idle(2);
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    bv        = '0;
    set_in(1, 0, 0, 32'd1, 32'd1);
    in_valid = 1'b1;
    tick();
    for (int r = 2; r <= 6; r++) begin
      set_in(r, 15, 0, 32'd0, 32'd0);
      tick();
    end
    if ({io.count, io.out_valid} !== {CW'(5), 1'b1})
      $display("FAIL preflush: got cnt=%0d v=%b want 5 1", io.count, io.out_valid);
    else passed++;
    checks++;
    set_in(7, 0, 0, 32'd7, 32'd7);
    flush = 1'b1;
    tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if ({io.count, io.out_valid} !== {CW'(0), 1'b0})
        $display("FAIL flush_clear: got cnt=%0d v=%b want 0 0", io.count, io.out_valid);
      else passed++;
      checks++;
      tick();
    end
    if (obs_vec() !== exp_vec())
      $display("FAIL flush_model: dut=%h model=%h", obs_vec(), exp_vec());
    else passed++;
    checks++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rdy       = ($urandom_range(0, 9) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      in_valid  = ($urandom_range(0, 9) < 6);
      out_ready = ($urandom_range(0, 9) < 7);
      set_in($urandom_range(0, 15),
             $urandom_range(0, 1) ? $urandom_range(1, 7) : 0,
             $urandom_range(0, 1) ? $urandom_range(1, 7) : 0,
             $urandom, $urandom);
      bv = '0;
      for (int k = 0; k < NCDB; k++)
        if ($urandom_range(0, 1)) set_bus(k, $urandom_range(0, 7), $urandom);
      if ($urandom_range(0, 7) == 0) begin
        set_bus(0, 5, $urandom);
        set_bus(1, 5, $urandom);
      end
      tick();
      if (obs_vec() !== exp_vec())
        $display("FAIL random_model cyc %0d: dut=%h model=%h", c, obs_vec(), exp_vec());
      else passed++;
      checks++;
    end
    rdy = 1'b1;
    idle(DEPTH + 4);
  endtask

  initial begin
    rst       = 1'b0;
    rdy       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    din       = '0;
    bv        = '0;
    brob      = '0;
    bdat      = '0;
    mq.delete();
    m_ov  = 1'b0;
    m_out = '0;
    test_reset();
    test_min_latency();
    test_wakeup();
    test_bypass();
    test_full_order();
    test_backpressure();
    test_flush();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
